// File: rtl/uart_host_link_if.sv
// Host job-source bus: job offer/accept handshake plus the GET_INFO request line.
interface uart_host_link_if;
  logic         job_valid;
  logic         job_ready;
  logic [255:0] job_midstate;
  logic [95:0]  job_work_data;
  logic [31:0]  job_nonce_min;
  logic [31:0]  job_nonce_max;
  logic         info_req;

  // Job source side
  modport master (
    output job_valid, job_midstate, job_work_data, job_nonce_min, job_nonce_max, info_req,
    input  job_ready
  );

  // Link side
  modport slave (
    input  job_valid, job_midstate, job_work_data, job_nonce_min, job_nonce_max, info_req,
    output job_ready
  );
endinterface

// File: rtl/uart_host_link.sv
// uart_host_link: host-side peer of the miner comm block. Frames PUSH_JOB / GET_INFO
// packets onto a byte UART and parses inbound ACK / INVALID / INFO / NONCE packets,
// tracking one outstanding request with a response timeout.
module uart_host_link #(
  parameter int unsigned RESP_TIMEOUT  = 12000000,
  parameter int unsigned RX_GAP_CYCLES = 120000,
  parameter int unsigned RX_MAX_LEN    = 16
) (
  input  logic        comm_clk,
  input  logic        reset,
  uart_host_link_if.slave host,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  input  logic        tx_busy,
  input  logic        rx_received,
  input  logic [7:0]  rx_byte,
  output logic        resp_valid,
  output logic [7:0]  resp_type,
  output logic [7:0]  resp_len,
  output logic [63:0] resp_payload,
  output logic        ack_valid,
  output logic        nonce_valid,
  output logic [31:0] nonce,
  output logic        proto_error,
  output logic        timeout
);

  localparam int unsigned PKT_BITS = 480;
  localparam int unsigned TMR_W    = $clog2(RESP_TIMEOUT + 1);
  localparam int unsigned GAP_W    = $clog2(RX_GAP_CYCLES + 1);

  localparam logic [7:0] JOB_LEN        = 8'h3C;
  localparam logic [7:0] INFO_LEN       = 8'h08;
  localparam logic [7:0] TYPE_GET_INFO  = 8'h00;
  localparam logic [7:0] TYPE_INVALID   = 8'h01;
  localparam logic [7:0] TYPE_PUSH_JOB  = 8'h02;
  localparam logic [7:0] TYPE_NONCE     = 8'h03;
  localparam logic [7:0] TYPE_ACK       = 8'h04;
  localparam logic [7:0] ACK_LEN        = 8'h08;
  localparam logic [7:0] NONCE_LEN      = 8'h0C;

  typedef enum logic [1:0] {T_IDLE, T_SEND, T_GUARD, T_WAIT_RESP} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_BODY, R_DROP} rx_state_t;

  tx_state_t             tx_state;
  logic [PKT_BITS-1:0]   tx_sr;
  logic [7:0]            tx_len;
  logic [7:0]            tx_cnt;
  logic [TMR_W-1:0]      tx_timer;

  rx_state_t             rx_state;
  logic [7:0]            rx_len_q;
  logic [7:0]            rx_idx;
  logic [7:0]            rx_type_q;
  logic                  rx_bad_q;
  logic [GAP_W-1:0]      rx_gap;

  logic hdr_byte_c;
  logic rx_bad_c;
  logic rx_last_c;
  logic resp_done_c;
  logic resp_ends_wait_c;

  // Inbound byte classification for the current R_BODY index
  assign hdr_byte_c       = (rx_idx == 8'd1) || (rx_idx == 8'd2) ||
                            ((rx_idx >= 8'd4) && (rx_idx <= 8'd7));
  assign rx_bad_c         = rx_bad_q | (hdr_byte_c & (rx_byte != 8'h00));
  assign rx_last_c        = (rx_idx == (rx_len_q - 8'd1));
  assign resp_done_c      = (rx_state == R_BODY) & rx_received & rx_last_c & ~rx_bad_c;
  assign resp_ends_wait_c = resp_done_c & ((rx_type_q == TYPE_GET_INFO) ||
                                           (rx_type_q == TYPE_INVALID)  ||
                                           (rx_type_q == TYPE_ACK));

  // Outbound framer and request tracker; the UART busy flag lags tx_start by one cycle
  always_ff @(posedge comm_clk) begin
    if (reset) begin
      tx_state       <= T_IDLE;
      tx_sr          <= '0;
      tx_len         <= '0;
      tx_cnt         <= '0;
      tx_timer       <= '0;
      tx_start       <= 1'b0;
      tx_byte        <= '0;
      timeout        <= 1'b0;
      host.job_ready <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      timeout  <= 1'b0;
      case (tx_state)
        T_IDLE: begin
          host.job_ready <= 1'b1;
          if (host.job_ready && host.job_valid) begin
            tx_sr          <= {JOB_LEN, 8'h00, 8'h00, TYPE_PUSH_JOB, 32'h0,
                               host.job_midstate, host.job_work_data,
                               host.job_nonce_min, host.job_nonce_max};
            tx_len         <= JOB_LEN;
            tx_cnt         <= '0;
            tx_state       <= T_SEND;
            host.job_ready <= 1'b0;
          end else if (host.job_ready && host.info_req) begin
            tx_sr          <= {INFO_LEN, 8'h00, 8'h00, TYPE_GET_INFO, 448'h0};
            tx_len         <= INFO_LEN;
            tx_cnt         <= '0;
            tx_state       <= T_SEND;
            host.job_ready <= 1'b0;
          end
        end
        T_SEND: begin
          if (!tx_busy) begin
            tx_byte  <= tx_sr[PKT_BITS-1 -: 8];
            tx_sr    <= {tx_sr[PKT_BITS-9:0], 8'h00};
            tx_start <= 1'b1;
            tx_cnt   <= tx_cnt + 8'd1;
            tx_state <= T_GUARD;
          end
        end
        T_GUARD: begin
          if (tx_cnt == tx_len) begin
            tx_timer <= '0;
            tx_state <= T_WAIT_RESP;
          end else begin
            tx_state <= T_SEND;
          end
        end
        T_WAIT_RESP: begin
          if (resp_ends_wait_c) begin
            tx_state       <= T_IDLE;
            host.job_ready <= 1'b1;
          end else if (tx_timer == TMR_W'(RESP_TIMEOUT - 1)) begin
            timeout        <= 1'b1;
            tx_state       <= T_IDLE;
            host.job_ready <= 1'b1;
          end else begin
            tx_timer <= tx_timer + TMR_W'(1);
          end
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  // Inbound parser with inter-byte gap watchdog; independent of the TX side
  always_ff @(posedge comm_clk) begin
    if (reset) begin
      rx_state     <= R_IDLE;
      rx_len_q     <= '0;
      rx_idx       <= '0;
      rx_type_q    <= '0;
      rx_bad_q     <= 1'b0;
      rx_gap       <= '0;
      resp_valid   <= 1'b0;
      resp_type    <= '0;
      resp_len     <= '0;
      resp_payload <= '0;
      ack_valid    <= 1'b0;
      nonce_valid  <= 1'b0;
      nonce        <= '0;
      proto_error  <= 1'b0;
    end else begin
      resp_valid  <= 1'b0;
      ack_valid   <= 1'b0;
      nonce_valid <= 1'b0;
      proto_error <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (rx_received) begin
            rx_len_q     <= rx_byte;
            resp_payload <= '0;
            rx_idx       <= 8'd1;
            rx_bad_q     <= 1'b0;
            rx_type_q    <= '0;
            rx_gap       <= '0;
            if (rx_byte < 8'd8) begin
              proto_error <= 1'b1;
            end else if (rx_byte > 8'(RX_MAX_LEN)) begin
              rx_state <= R_DROP;
            end else begin
              rx_state <= R_BODY;
            end
          end
        end
        R_BODY: begin
          if (rx_received) begin
            rx_gap   <= '0;
            rx_bad_q <= rx_bad_c;
            if (rx_idx == 8'd3) rx_type_q <= rx_byte;
            if (rx_idx >= 8'd8) resp_payload <= {resp_payload[55:0], rx_byte};
            if (rx_last_c) begin
              rx_state <= R_IDLE;
              if (rx_bad_c) begin
                proto_error <= 1'b1;
              end else begin
                resp_valid  <= 1'b1;
                resp_type   <= rx_type_q;
                resp_len    <= rx_len_q;
                ack_valid   <= (rx_type_q == TYPE_ACK) && (rx_len_q == ACK_LEN);
                nonce_valid <= (rx_type_q == TYPE_NONCE) && (rx_len_q == NONCE_LEN);
                if ((rx_type_q == TYPE_NONCE) && (rx_len_q == NONCE_LEN))
                  nonce <= {resp_payload[23:0], rx_byte};
              end
            end else begin
              rx_idx <= rx_idx + 8'd1;
            end
          end else if (rx_gap == GAP_W'(RX_GAP_CYCLES - 1)) begin
            proto_error <= 1'b1;
            rx_state    <= R_IDLE;
          end else begin
            rx_gap <= rx_gap + GAP_W'(1);
          end
        end
        R_DROP: begin
          if (rx_received) begin
            rx_gap <= '0;
            if (rx_last_c) begin
              proto_error <= 1'b1;
              rx_state    <= R_IDLE;
            end else begin
              rx_idx <= rx_idx + 8'd1;
            end
          end else if (rx_gap == GAP_W'(RX_GAP_CYCLES - 1)) begin
            proto_error <= 1'b1;
            rx_state    <= R_IDLE;
          end else begin
            rx_gap <= rx_gap + GAP_W'(1);
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_host_link.sv
// Testbench for uart_host_link: UART byte-sink model, randomized jobs and inbound
// packets, checked against a packet-level reference model.
module tb_uart_host_link;

  localparam int unsigned RESP_TO = 100;
  localparam int unsigned GAP     = 40;
  localparam int unsigned MAXL    = 16;

  logic        comm_clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_busy = 1'b0;
  logic        rx_received = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        resp_valid;
  logic [7:0]  resp_type;
  logic [7:0]  resp_len;
  logic [63:0] resp_payload;
  logic        ack_valid;
  logic        nonce_valid;
  logic [31:0] nonce;
  logic        proto_error;
  logic        timeout;

  uart_host_link_if host();

  uart_host_link #(
    .RESP_TIMEOUT (RESP_TO),
    .RX_GAP_CYCLES(GAP),
    .RX_MAX_LEN   (MAXL)
  ) dut (
    .comm_clk    (comm_clk),
    .reset       (reset),
    .host        (host),
    .tx_start    (tx_start),
    .tx_byte     (tx_byte),
    .tx_busy     (tx_busy),
    .rx_received (rx_received),
    .rx_byte     (rx_byte),
    .resp_valid  (resp_valid),
    .resp_type   (resp_type),
    .resp_len    (resp_len),
    .resp_payload(resp_payload),
    .ack_valid   (ack_valid),
    .nonce_valid (nonce_valid),
    .nonce       (nonce),
    .proto_error (proto_error),
    .timeout     (timeout)
  );

  always #5 comm_clk = ~comm_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observation state
  int          cyc = 0;
  int          busy_left = 0;
  int          n_start = 0, n_resp = 0, n_perr = 0, n_ack = 0, n_nonce = 0, n_to = 0;
  int          last_start_cyc = 0, last_to_cyc = 0;
  logic [7:0]  txq[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  rx_pkt[$];
  logic [7:0]  got_type, got_len;
  logic [63:0] got_payload;

  // UART byte sink (busy rises one cycle after tx_start) and pulse monitor
  always @(negedge comm_clk) begin
    cyc++;
    if (reset) begin
      busy_left = 0;
      tx_busy   = 1'b0;
    end else begin
      if (tx_start) begin
        txq.push_back(tx_byte);
        n_start++;
        last_start_cyc = cyc;
        tx_busy   = 1'b1;
        busy_left = $urandom_range(1, 4);
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
      if (resp_valid) begin
        n_resp++;
        got_type    = resp_type;
        got_len     = resp_len;
        got_payload = resp_payload;
      end
      if (proto_error) n_perr++;
      if (ack_valid)   n_ack++;
      if (nonce_valid) n_nonce++;
      if (timeout) begin
        n_to++;
        last_to_cyc = cyc;
      end
    end
  end

  // Reference model: outcome of one inbound packet from the framing rules
  logic [7:0]  m_type;
  logic [63:0] m_payload;
  int          m_resp, m_err, m_ack, m_nonce;

  function automatic void run_model();
    int  len;
    bit  bad;
    len = int'(rx_pkt[0]);
    m_resp = 0; m_err = 0; m_ack = 0; m_nonce = 0;
    m_payload = 64'h0; m_type = 8'h00;
    if (len < 8 || len > int'(MAXL)) begin
      m_err = 1;
    end else begin
      bad = 1'b0;
      m_type = rx_pkt[3];
      for (int i = 1; i < len; i++) begin
        if (i < 8 && i != 3 && rx_pkt[i] != 8'h00) bad = 1'b1;
        if (i >= 8) m_payload = (m_payload << 8) | 64'(rx_pkt[i]);
      end
      if (bad) m_err = 1;
      else begin
        m_resp  = 1;
        m_ack   = (m_type == 8'h04 && len == 8)  ? 1 : 0;
        m_nonce = (m_type == 8'h03 && len == 12) ? 1 : 0;
      end
    end
  endfunction

  task automatic feed_pkt();
    foreach (rx_pkt[i]) begin
      @(negedge comm_clk);
      rx_byte     = rx_pkt[i];
      rx_received = 1'b1;
      @(negedge comm_clk);
      rx_received = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge comm_clk);
    end
  endtask

  task automatic send_and_check(input string tag);
    int r0, e0, a0, k0;
    r0 = n_resp; e0 = n_perr; a0 = n_ack; k0 = n_nonce;
    run_model();
    feed_pkt();
    repeat (3) @(negedge comm_clk);
    check_eq($sformatf("%s_resp", tag),  64'(n_resp - r0),  64'(m_resp));
    check_eq($sformatf("%s_perr", tag),  64'(n_perr - e0),  64'(m_err));
    check_eq($sformatf("%s_ack", tag),   64'(n_ack - a0),   64'(m_ack));
    check_eq($sformatf("%s_nonce", tag), 64'(n_nonce - k0), 64'(m_nonce));
    if (m_resp != 0) begin
      check_eq($sformatf("%s_type", tag), 64'(got_type), 64'(m_type));
      check_eq($sformatf("%s_len", tag),  64'(got_len),  64'(rx_pkt[0]));
      check_eq($sformatf("%s_payload", tag), got_payload, m_payload);
    end
    if (m_nonce != 0) check_eq($sformatf("%s_nonceval", tag), 64'(nonce), 64'(m_payload[31:0]));
  endtask

  // Offer a job (optionally with info_req raised too) and build the expected byte stream
  task automatic push_job(input logic [255:0] ms, input logic [95:0] wd,
                          input logic [31:0] mn, input logic [31:0] mx, input bit with_info);
    logic [415:0] pl;
    logic         rdy;
    int           k;
    pl = {ms, wd, mn, mx};
    exp_tx = '{8'h3C, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 52; i++) exp_tx.push_back(pl[415 - 8*i -: 8]);
    txq.delete();
    @(negedge comm_clk);
    host.job_midstate  = ms;
    host.job_work_data = wd;
    host.job_nonce_min = mn;
    host.job_nonce_max = mx;
    host.job_valid     = 1'b1;
    host.info_req      = with_info;
    k = 0;
    do begin
      rdy = host.job_ready;
      @(negedge comm_clk);
      k++;
    end while (!rdy && k < 200);
    host.job_valid = 1'b0;
    host.info_req  = 1'b0;
    if (!rdy) check_eq("job_accept", 64'(rdy), 64'd1);
  endtask

  task automatic push_info();
    logic rdy;
    int   k;
    exp_tx = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    txq.delete();
    @(negedge comm_clk);
    host.info_req = 1'b1;
    k = 0;
    do begin
      rdy = host.job_ready;
      @(negedge comm_clk);
      k++;
    end while (!rdy && k < 200);
    host.info_req = 1'b0;
    if (!rdy) check_eq("info_accept", 64'(rdy), 64'd1);
  endtask

  // Wait (bounded) for the whole expected stream, then compare it byte by byte
  task automatic wait_tx(input string tag);
    int k;
    k = 0;
    while (txq.size() < exp_tx.size() && k < 2000) begin
      @(negedge comm_clk);
      k++;
    end
    check_eq($sformatf("%s_txcount", tag), 64'(txq.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < txq.size(); i++)
      check_eq($sformatf("%s_txb%0d", tag, i), 64'(txq[i]), 64'(exp_tx[i]));
  endtask

  task automatic rand_pkt();
    int kind, len, j;
    kind = $urandom_range(0, 5);
    rx_pkt.delete();
    if (kind == 0) begin
      rx_pkt.push_back(8'($urandom_range(0, 7)));
    end else if (kind == 1) begin
      len = $urandom_range(int'(MAXL) + 1, 40);
      rx_pkt.push_back(8'(len));
      for (int i = 1; i < len; i++) rx_pkt.push_back(8'($urandom_range(0, 255)));
    end else begin
      len = (kind == 2) ? 12 : (kind == 3) ? 8 : $urandom_range(8, int'(MAXL));
      rx_pkt = '{8'(len), 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      rx_pkt[3] = (kind == 2) ? 8'h03 : (kind == 3) ? 8'h04 : 8'($urandom_range(0, 4));
      for (int i = 8; i < len; i++) rx_pkt.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 4) == 0) begin
        j = $urandom_range(0, 5);
        rx_pkt[(j < 2) ? j + 1 : j + 2] = 8'($urandom_range(1, 255));
      end
    end
  endtask

  task automatic rand_job(input bit with_info);
    push_job({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom}, $urandom, $urandom, with_info);
  endtask

  initial begin
    logic [255:0] ms;
    int           e0, s0, t0, to0, k;

    host.job_valid     = 1'b0;
    host.info_req      = 1'b0;
    host.job_midstate  = '0;
    host.job_work_data = '0;
    host.job_nonce_min = '0;
    host.job_nonce_max = '0;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge comm_clk);
    check_eq("rst_job_ready", 64'(host.job_ready), 64'd0);
    check_eq("rst_tx_start",  64'(tx_start), 64'd0);
    check_eq("rst_tx_byte",   64'(tx_byte), 64'd0);
    check_eq("rst_resp",      64'(resp_valid), 64'd0);
    check_eq("rst_payload",   resp_payload, 64'd0);
    check_eq("rst_nonce",     64'(nonce), 64'd0);
    check_eq("rst_perr",      64'(proto_error), 64'd0);
    check_eq("rst_timeout",   64'(timeout), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge comm_clk);
    check_eq("idle_job_ready", 64'(host.job_ready), 64'd1);

    // Directed job, then ACK
    for (int i = 0; i < 32; i++) ms[255 - 8*i -: 8] = 8'(i);
    push_job(ms, {6{16'hAABB}}, 32'h0, 32'hFFFF_FFFF, 1'b0);
    wait_tx("job1");
    check_eq("job1_busy", 64'(host.job_ready), 64'd0);
    rx_pkt = '{8'h08, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    send_and_check("ack1");
    check_eq("ack1_ready", 64'(host.job_ready), 64'd1);

    // NONCE arriving while the job is still being sent
    rand_job(1'b0);
    rx_pkt = '{8'h0C, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_and_check("nonce1");
    check_eq("nonce1_value", 64'(nonce), 64'hDEAD_BEEF);
    wait_tx("job2");
    check_eq("job2_still_wait", 64'(host.job_ready), 64'd0);
    rx_pkt = '{8'h08, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    send_and_check("ack2");
    check_eq("ack2_ready", 64'(host.job_ready), 64'd1);

    // GET_INFO and its 16-byte reply
    push_info();
    wait_tx("info");
    rx_pkt = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h13, 8'h37, 8'h0D, 8'h13};
    send_and_check("info");
    check_eq("info_payload", resp_payload, 64'hDEAD_BEEF_1337_0D13);
    check_eq("info_type", 64'(resp_type), 64'd0);
    check_eq("info_ready", 64'(host.job_ready), 64'd1);

    // Random jobs ending in INFO / INVALID / ACK
    for (int n = 0; n < 4; n++) begin
      rand_job(1'b0);
      wait_tx($sformatf("rjob%0d", n));
      k = $urandom_range(0, 2);
      rx_pkt = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      rx_pkt[3] = (k == 0) ? 8'h00 : (k == 1) ? 8'h01 : 8'h04;
      send_and_check($sformatf("rresp%0d", n));
      check_eq($sformatf("rready%0d", n), 64'(host.job_ready), 64'd1);
    end

    // Job and info_req together: job wins, info_req is not remembered
    rand_job(1'b1);
    wait_tx("both");
    rx_pkt = '{8'h08, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    send_and_check("both_ack");
    repeat (30) @(negedge comm_clk);
    check_eq("info_not_held", 64'(txq.size()), 64'd60);

    // Response timeout
    rand_job(1'b0);
    wait_tx("tojob");
    t0 = last_start_cyc;
    to0 = n_to;
    k = 0;
    while (n_to == to0 && k < 400) begin
      @(negedge comm_clk);
      k++;
    end
    check_eq("timeout_seen", 64'(n_to - to0), 64'd1);
    check_eq("timeout_latency", 64'(last_to_cyc - t0), 64'(RESP_TO + 1));
    @(negedge comm_clk);
    check_eq("timeout_ready", 64'(host.job_ready), 64'd1);

    // Malformed inbound packets
    rx_pkt = '{8'h05};
    send_and_check("short");
    rx_pkt = '{8'h20};
    for (int i = 1; i < 32; i++) rx_pkt.push_back(8'($urandom_range(0, 255)));
    send_and_check("long");
    rx_pkt = '{8'h08, 8'h00, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    send_and_check("badhdr");

    // Random inbound traffic
    for (int n = 0; n < 30; n++) begin
      rand_pkt();
      send_and_check($sformatf("rpkt%0d", n));
    end

    // Inter-byte gap abort, then recovery
    e0 = n_perr;
    rx_pkt = '{8'h0C, 8'h00, 8'h00, 8'h03};
    feed_pkt();
    repeat (GAP - 10) @(negedge comm_clk);
    check_eq("gap_early", 64'(n_perr - e0), 64'd0);
    repeat (30) @(negedge comm_clk);
    check_eq("gap_abort", 64'(n_perr - e0), 64'd1);
    rx_pkt = '{8'h08, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    send_and_check("gap_recover");

    // Reset in the middle of a job transmission
    rand_job(1'b0);
    k = 0;
    while (txq.size() < 10 && k < 500) begin
      @(negedge comm_clk);
      k++;
    end
    reset = 1'b1;
    repeat (2) @(negedge comm_clk);
    check_eq("mrst_tx_start",  64'(tx_start), 64'd0);
    check_eq("mrst_tx_byte",   64'(tx_byte), 64'd0);
    check_eq("mrst_job_ready", 64'(host.job_ready), 64'd0);
    check_eq("mrst_payload",   resp_payload, 64'd0);
    check_eq("mrst_nonce",     64'(nonce), 64'd0);
    check_eq("mrst_type",      64'(resp_type), 64'd0);
    s0 = n_start;
    reset = 1'b0;
    repeat (200) @(negedge comm_clk);
    check_eq("mrst_no_tx", 64'(n_start - s0), 64'd0);
    check_eq("mrst_ready", 64'(host.job_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
